// File: rtl/coreaxi4dma_pkg.sv
// Shared definitions for the CoreAXI4DMA control-path blocks: FSM encodings,
// AXI response codes and control-bus widths.
package coreaxi4dma_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_REQ  = 3'd1;
  localparam logic [2:0] ST_WR_RESP = 3'd2;
  localparam logic [2:0] ST_RD_REQ  = 3'd3;
  localparam logic [2:0] ST_RD_RESP = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    WR_REQ  = ST_WR_REQ,
    WR_RESP = ST_WR_RESP,
    RD_REQ  = ST_RD_REQ,
    RD_RESP = ST_RD_RESP
  } ctrl_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int CTRL_ADDR_WIDTH = 11;
  localparam int CTRL_DATA_WIDTH = 32;

  // Control-bus addresses are word aligned; the byte offset is dropped.
  function automatic logic [CTRL_ADDR_WIDTH-1:0] word_addr(input logic [CTRL_ADDR_WIDTH-1:0] a);
    return {a[CTRL_ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/coreaxi4dma_ctrl_timeout.sv
// Control-bus response timer: counts cycles spent waiting on the bus and
// flags expiry on the last allowed cycle. Only built with CTRL_TIMEOUT_EN.
module coreaxi4dma_ctrl_timeout #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic active,
  output logic expired
);

  localparam int CW = ($clog2(TIMEOUT_CYCLES) > 9) ? $clog2(TIMEOUT_CYCLES) : 9;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Idle cycles hold the count at zero, so every request starts from a clean count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      count <= '0;
    else if (!active)
      count <= '0;
    else if (count != LAST)
      count <= count + CW'(1);
  end

  assign expired = active && (count == LAST);

endmodule

// File: rtl/coreaxi4dma_axilite_target_ctrl.sv
// AXI4-Lite target bridging host register accesses onto the single-beat DMA control bus.
// Optional response timeout (SLVERR on expiry) is enabled by defining CTRL_TIMEOUT_EN.
module coreaxi4dma_axilite_target_ctrl
  import coreaxi4dma_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        AWVALID,
  output logic                        AWREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]   AWADDR,
  input  logic                        WVALID,
  output logic                        WREADY,
  input  logic [31:0]                 WDATA,
  input  logic [3:0]                  WSTRB,
  output logic                        BVALID,
  input  logic                        BREADY,
  output logic [1:0]                  BRESP,
  input  logic                        ARVALID,
  output logic                        ARREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]   ARADDR,
  output logic                        RVALID,
  input  logic                        RREADY,
  output logic [31:0]                 RDATA,
  output logic [1:0]                  RRESP,
  output logic                        ctrlSel,
  output logic                        ctrlWr,
  output logic [CTRL_ADDR_WIDTH-1:0]  ctrlAddr,
  output logic [CTRL_DATA_WIDTH-1:0]  ctrlWrData,
  output logic [3:0]                  ctrlWrStrbs,
  input  logic                        ctrlWrRdy,
  input  logic [CTRL_DATA_WIDTH-1:0]  ctrlRdData,
  input  logic                        ctrlRdValid
);

  ctrl_state_t state, state_nxt;
  logic        last_wr;
  logic        idle, wr_pend, rd_pend, grant_wr, grant_rd;
  logic        expired;

  // Readies are held low during reset even though the state already reads IDLE.
  assign idle     = (state == IDLE) && !reset;
  assign wr_pend  = AWVALID && WVALID;
  assign rd_pend  = ARVALID;
  assign grant_wr = idle && wr_pend && (!rd_pend || !last_wr);
  assign grant_rd = idle && rd_pend && (!wr_pend || last_wr);

  assign AWREADY = grant_wr;
  assign WREADY  = grant_wr;
  assign ARREADY = grant_rd;
  assign ctrlSel = (state == WR_REQ) || (state == RD_REQ);

`ifdef CTRL_TIMEOUT_EN
  coreaxi4dma_ctrl_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .active  (ctrlSel),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{AWADDR[AXI_ADDR_WIDTH-1:11], AWADDR[1:0],
                         ARADDR[AXI_ADDR_WIDTH-1:11], ARADDR[1:0], (TIMEOUT_CYCLES < 2)};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_wr)      state_nxt = WR_REQ;
        else if (grant_rd) state_nxt = RD_REQ;
      end
      WR_REQ:  if (ctrlWrRdy || expired)   state_nxt = WR_RESP;
      WR_RESP: if (BREADY)                 state_nxt = IDLE;
      RD_REQ:  if (ctrlRdValid || expired) state_nxt = RD_RESP;
      RD_RESP: if (RREADY)                 state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_wr     <= 1'b0;
      ctrlWr      <= 1'b0;
      ctrlAddr    <= '0;
      ctrlWrData  <= '0;
      ctrlWrStrbs <= '0;
      BVALID      <= 1'b0;
      BRESP       <= RESP_OKAY;
      RVALID      <= 1'b0;
      RDATA       <= '0;
      RRESP       <= RESP_OKAY;
    end else begin
      state <= state_nxt;

      // Bus outputs only change on a grant, so they keep their last value while idle.
      if (grant_wr) begin
        last_wr     <= 1'b1;
        ctrlWr      <= 1'b1;
        ctrlAddr    <= word_addr(AWADDR[CTRL_ADDR_WIDTH-1:0]);
        ctrlWrData  <= WDATA;
        ctrlWrStrbs <= WSTRB;
      end else if (grant_rd) begin
        last_wr     <= 1'b0;
        ctrlWr      <= 1'b0;
        ctrlAddr    <= word_addr(ARADDR[CTRL_ADDR_WIDTH-1:0]);
      end

      if (state == WR_REQ && (ctrlWrRdy || expired)) begin
        BVALID <= 1'b1;
        BRESP  <= ctrlWrRdy ? RESP_OKAY : RESP_SLVERR;
      end else if (state == WR_RESP && BREADY) begin
        BVALID <= 1'b0;
      end

      // A response arriving on the expiry cycle takes priority over the timeout.
      if (state == RD_REQ && ctrlRdValid) begin
        RVALID <= 1'b1;
        RDATA  <= ctrlRdData;
        RRESP  <= RESP_OKAY;
      end else if (state == RD_REQ && expired) begin
        RVALID <= 1'b1;
        RDATA  <= '0;
        RRESP  <= RESP_SLVERR;
      end else if (state == RD_RESP && RREADY) begin
        RVALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_coreaxi4dma_axilite_target_ctrl.sv
// Directed self-checking bench for coreaxi4dma_axilite_target_ctrl; timeout
// expectations follow CTRL_TIMEOUT_EN.
module tb_coreaxi4dma_axilite_target_ctrl;
  import coreaxi4dma_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;
  logic        ctrlSel, ctrlWr, ctrlWrRdy, ctrlRdValid;
  logic [10:0] ctrlAddr;
  logic [31:0] ctrlWrData, ctrlRdData;
  logic [3:0]  ctrlWrStrbs;

  coreaxi4dma_axilite_target_ctrl #(
    .AXI_ADDR_WIDTH (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock (clock), .reset (reset),
    .AWVALID (AWVALID), .AWREADY (AWREADY), .AWADDR (AWADDR),
    .WVALID (WVALID), .WREADY (WREADY), .WDATA (WDATA), .WSTRB (WSTRB),
    .BVALID (BVALID), .BREADY (BREADY), .BRESP (BRESP),
    .ARVALID (ARVALID), .ARREADY (ARREADY), .ARADDR (ARADDR),
    .RVALID (RVALID), .RREADY (RREADY), .RDATA (RDATA), .RRESP (RRESP),
    .ctrlSel (ctrlSel), .ctrlWr (ctrlWr), .ctrlAddr (ctrlAddr),
    .ctrlWrData (ctrlWrData), .ctrlWrStrbs (ctrlWrStrbs),
    .ctrlWrRdy (ctrlWrRdy), .ctrlRdData (ctrlRdData), .ctrlRdValid (ctrlRdValid)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Control-bus read responder: returns rd_data rd_delay cycles after ctrlSel rises.
  logic        rd_en = 1'b0;
  logic        rd_stray = 1'b0;
  int          rd_delay = 0;
  logic [31:0] rd_data = 32'h0;
  int          sel_cnt = 0;

  always @(negedge clock) begin
    if (ctrlSel && !ctrlWr) sel_cnt = sel_cnt + 1;
    else                    sel_cnt = 0;
    ctrlRdValid = rd_stray || (rd_en && (sel_cnt > rd_delay));
    ctrlRdData  = rd_data;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int bwait, input logic [10:0] exp_addr, input int exp_lat);
    int n;
    @(negedge clock);
    AWADDR = addr; WDATA = data; WSTRB = strb; AWVALID = 1'b1; WVALID = 1'b1;
    #1;
    n = 0;
    while (!(AWREADY && WREADY) && n < 50) begin @(negedge clock); #1; n++; end
    check("wr_accept", 32'(n < 50), 32'h1);
    @(posedge clock); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge clock);
    check("wr_sel_wr", 32'({ctrlSel, ctrlWr}), 32'h3);
    check("wr_addr", 32'(ctrlAddr), 32'(exp_addr));
    check("wr_data", ctrlWrData, data);
    check("wr_strb", 32'(ctrlWrStrbs), 32'(strb));
    n = 1;
    while (!BVALID && n < 50) begin @(negedge clock); n++; end
    check("wr_latency", n, exp_lat);
    check("wr_sel_low", 32'(ctrlSel), 32'h0);
    check("bresp", 32'(BRESP), 32'(RESP_OKAY));
    for (int i = 0; i < bwait; i++) begin
      @(negedge clock);
      check("bvalid_hold", 32'(BVALID), 32'h1);
    end
    BREADY = 1'b1;
    @(negedge clock);
    BREADY = 1'b0;
    check("bvalid_clear", 32'(BVALID), 32'h0);
  endtask

  task automatic run_read(input logic [31:0] addr, input logic [31:0] data, input int delay,
                          input int rwait, input logic [10:0] exp_addr, input int exp_lat);
    int n;
    rd_en = 1'b1; rd_delay = delay; rd_data = data;
    @(negedge clock);
    ARADDR = addr; ARVALID = 1'b1;
    #1;
    n = 0;
    while (!ARREADY && n < 50) begin @(negedge clock); #1; n++; end
    check("rd_accept", 32'(n < 50), 32'h1);
    @(posedge clock); #1;
    ARVALID = 1'b0;
    @(negedge clock);
    check("rd_sel_wr", 32'({ctrlSel, ctrlWr}), 32'h2);
    check("rd_addr", 32'(ctrlAddr), 32'(exp_addr));
    n = 1;
    while (!RVALID && n < 50) begin @(negedge clock); n++; end
    check("rd_latency", n, exp_lat);
    check("rd_sel_low", 32'(ctrlSel), 32'h0);
    check("rdata", RDATA, data);
    check("rresp", 32'(RRESP), 32'(RESP_OKAY));
    for (int i = 0; i < rwait; i++) begin
      @(negedge clock);
      check("rvalid_hold", 32'({RVALID, (RDATA == data)}), 32'h3);
    end
    RREADY = 1'b1;
    @(negedge clock);
    RREADY = 1'b0;
    check("rvalid_clear", 32'(RVALID), 32'h0);
  endtask

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          delay;
    int          wait_cycles;
    logic [10:0] exp_addr;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int   n, bad, wr_left, rd_left, gi, pulses;
    logic prev_sel, hs_w, hs_r;
    logic [7:0] order;

    vecs[0] = '{1'b1, 32'h0000_0060, 32'hA5A5_0001, 4'hF, 0, 0, 11'h060, 2};
    vecs[1] = '{1'b0, 32'h0000_0463, 32'h1234_5678, 4'h0, 3, 5, 11'h460, 5};
    vecs[2] = '{1'b1, 32'hFFFF_F7FE, 32'hDEAD_BEEF, 4'h5, 0, 2, 11'h7FC, 2};
    vecs[3] = '{1'b0, 32'h0000_0804, 32'hCAFE_0000, 4'h0, 0, 0, 11'h004, 2};
    vecs[4] = '{1'b1, 32'h0000_03FF, 32'h0000_00FF, 4'h1, 0, 1, 11'h3FC, 2};
    vecs[5] = '{1'b0, 32'h0000_07FF, 32'h8000_0001, 4'h0, 1, 1, 11'h7FC, 3};
    // Read answered on the last cycle before a timeout would fire: still OKAY with data.
    vecs[6] = '{1'b0, 32'h0000_0120, 32'h5A5A_1234, 4'h0, 7, 0, 11'h120, 9};

    reset = 1'b1;
    AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 0; RREADY = 0;
    AWADDR = 0; ARADDR = 0; WDATA = 0; WSTRB = 0; ctrlWrRdy = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_outputs", 32'(|{AWREADY, WREADY, ARREADY, BVALID, BRESP, RVALID, RRESP, RDATA,
                                 ctrlSel, ctrlWr, ctrlAddr, ctrlWrData, ctrlWrStrbs}), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].is_wr)
        run_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].wait_cycles,
                  vecs[i].exp_addr, vecs[i].exp_lat);
      else
        run_read(vecs[i].addr, vecs[i].data, vecs[i].delay, vecs[i].wait_cycles,
                 vecs[i].exp_addr, vecs[i].exp_lat);
    end

    // Stray read-valid while idle must not produce a response.
    @(negedge clock);
    rd_stray = 1'b1;
    repeat (3) @(negedge clock);
    rd_stray = 1'b0;
    check("stray_rdvalid", 32'({RVALID, ctrlSel}), 32'h0);

    // AW waits for W: neither ready until both valids present.
    @(negedge clock);
    AWADDR = 32'h10C; WDATA = 32'h0F0F_0F0F; WSTRB = 4'hF; AWVALID = 1'b1;
    #1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (AWREADY || WREADY) bad++;
      @(negedge clock); #1;
    end
    check("aw_waits_for_w", bad, 0);
    WVALID = 1'b1;
    #1;
    check("aw_w_ready_together", 32'({AWREADY, WREADY}), 32'h3);
    @(posedge clock); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge clock);
    check("delayed_w_addr", 32'(ctrlAddr), 32'h10C);
    BREADY = 1'b1;
    n = 0;
    while (!BVALID && n < 20) begin @(negedge clock); n++; end
    check("delayed_w_bvalid", 32'(BVALID), 32'h1);
    @(negedge clock);
    BREADY = 1'b0;

    // Reset during RD_REQ: everything clears asynchronously.
    rd_en = 1'b0;
    @(negedge clock);
    ARADDR = 32'h200; ARVALID = 1'b1;
    #1;
    n = 0;
    while (!ARREADY && n < 20) begin @(negedge clock); #1; n++; end
    @(posedge clock); #1;
    ARVALID = 1'b0;
    repeat (2) @(negedge clock);
    check("pre_reset_sel", 32'(ctrlSel), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_sel", 32'(ctrlSel), 32'h0);
    check("async_reset_outputs", 32'(|{AWREADY, WREADY, ARREADY, BVALID, BRESP, RVALID, RRESP,
                                      RDATA, ctrlWr, ctrlAddr, ctrlWrData, ctrlWrStrbs}), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    run_read(32'h204, 32'h0BAD_F00D, 2, 0, 11'h204, 4);

    // Contended traffic: 4 writes and 4 reads all pending, grants must alternate from write.
    pulse_reset();
    rd_en = 1'b1; rd_delay = 1; rd_data = 32'h7777_0000;
    BREADY = 1'b1; RREADY = 1'b1;
    wr_left = 4; rd_left = 4; gi = 0; pulses = 0; prev_sel = 1'b0; order = 8'h0; bad = 0;
    @(negedge clock);
    AWADDR = 32'h100; WDATA = 32'h1111_0000; WSTRB = 4'hF; ARADDR = 32'h300;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      #1;
      if (ctrlSel && !prev_sel) begin
        if (gi < 8) order[gi] = ctrlWr;
        gi++;
        pulses++;
      end
      prev_sel = ctrlSel;
      if (AWREADY && ARREADY) bad++;
      hs_w = AWVALID && AWREADY;
      hs_r = ARVALID && ARREADY;
      if (wr_left == 0 && rd_left == 0 && !ctrlSel && !BVALID && !RVALID) break;
      @(posedge clock); #1;
      if (hs_w) begin
        wr_left--;
        AWADDR = AWADDR + 32'h4;
        if (wr_left == 0) begin AWVALID = 1'b0; WVALID = 1'b0; end
      end
      if (hs_r) begin
        rd_left--;
        ARADDR = ARADDR + 32'h4;
        if (rd_left == 0) ARVALID = 1'b0;
      end
      @(negedge clock);
    end
    check("arb_done", 32'({wr_left[3:0], rd_left[3:0]}), 32'h0);
    check("arb_pulses", pulses, 8);
    check("arb_order", 32'(order), 32'h55);
    check("arb_single_ready", bad, 0);
    BREADY = 1'b0; RREADY = 1'b0;

    // Read that is never answered.
    rd_en = 1'b0;
    @(negedge clock);
    ARADDR = 32'h040; ARVALID = 1'b1;
    #1;
    n = 0;
    while (!ARREADY && n < 20) begin @(negedge clock); #1; n++; end
    @(posedge clock); #1;
    ARVALID = 1'b0;
    @(negedge clock);
`ifdef CTRL_TIMEOUT_EN
    n = 0;
    while (ctrlSel && n < 50) begin n++; @(negedge clock); end
    check("timeout_sel_cycles", n, 8);
    check("timeout_rvalid", 32'(RVALID), 32'h1);
    check("timeout_rresp", 32'(RRESP), 32'(RESP_SLVERR));
    check("timeout_rdata", RDATA, 32'h0);
    RREADY = 1'b1;
    @(negedge clock);
    RREADY = 1'b0;
    check("timeout_rvalid_clear", 32'(RVALID), 32'h0);
`else
    repeat (1000) @(negedge clock);
    check("no_timeout_sel", 32'(ctrlSel), 32'h1);
    check("no_timeout_rvalid", 32'(RVALID), 32'h0);
    pulse_reset();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
